// File: rtl/traffic_pkg.sv
// ============================================================================
// Module      : traffic_pkg
// Description : Phase encoding, lamp codes and phase sequencing helper for the
//               NS/EW intersection phase controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package traffic_pkg;

  typedef enum logic [2:0] {
    NS_G     = 3'd0,
    NS_Y     = 3'd1,
    AR_1     = 3'd2,
    EW_G     = 3'd3,
    EW_Y     = 3'd4,
    AR_2     = 3'd5,
    FAILSAFE = 3'd6
  } phase_e;

  // Lamp drives are {red,yellow,green}
  localparam logic [2:0] LAMP_RED = 3'b100;
  localparam logic [2:0] LAMP_YEL = 3'b010;
  localparam logic [2:0] LAMP_GRN = 3'b001;
  localparam logic [2:0] LAMP_OFF = 3'b000;

  function automatic phase_e next_phase(input phase_e p);
    case (p)
      NS_G:    return NS_Y;
      NS_Y:    return AR_1;
      AR_1:    return EW_G;
      EW_G:    return EW_Y;
      EW_Y:    return AR_2;
      AR_2:    return NS_G;
      default: return AR_2;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/traffic_phase_fsm.sv
// ============================================================================
// Module      : traffic_phase_fsm
// Description : Two-approach phase sequencer (G->Y->all-red per approach) with
//               seconds countdown and blinking-red failsafe on fault.
//               Optional gap-out on vehicle sensors: define GAP_OUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module traffic_phase_fsm
  import traffic_pkg::*;
#(
  parameter int CNT_W     = 8,
  parameter int GREEN_NS  = 30,
  parameter int GREEN_EW  = 30,
  parameter int YELLOW    = 3,
  parameter int ALL_RED   = 1,
  parameter int MIN_GREEN = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tick_1hz,
  input  logic             tick_2hz,
  input  logic             fault,
  input  logic             car_ns,
  input  logic             car_ew,
  output logic [2:0]       ns_lamp,
  output logic [2:0]       ew_lamp,
  output logic [CNT_W-1:0] countdown,
  output logic [2:0]       phase
);

  phase_e           phase_q, phase_d, nxt_phase;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             blink_q, blink_d;
  logic [2:0]       ns_lamp_q, ns_lamp_d;
  logic [2:0]       ew_lamp_q, ew_lamp_d;
  logic             gap_out;

  function automatic logic [CNT_W-1:0] dur(input phase_e p);
    case (p)
      NS_G:       return CNT_W'(GREEN_NS);
      EW_G:       return CNT_W'(GREEN_EW);
      NS_Y, EW_Y: return CNT_W'(YELLOW);
      default:    return CNT_W'(ALL_RED);
    endcase
  endfunction

`ifdef GAP_OUT_EN
  // Gap-out once minimum green has elapsed, own approach empty, other side waiting
  assign gap_out = ((phase_q == NS_G) && (cnt_q <= CNT_W'(GREEN_NS - MIN_GREEN)) &&
                    !car_ns && car_ew) ||
                   ((phase_q == EW_G) && (cnt_q <= CNT_W'(GREEN_EW - MIN_GREEN)) &&
                    !car_ew && car_ns);
`else
  logic unused_sensors;
  assign unused_sensors = ^{car_ns, car_ew, MIN_GREEN};
  assign gap_out        = 1'b0;
`endif

  assign nxt_phase = next_phase(phase_q);

  always_comb begin
    phase_d = phase_q;
    cnt_d   = cnt_q;
    blink_d = blink_q;
    if (fault) begin
      phase_d = FAILSAFE;
      cnt_d   = '0;
      blink_d = (phase_q == FAILSAFE) ? (blink_q ^ tick_2hz) : 1'b1;
    end else if (phase_q == FAILSAFE) begin
      blink_d = blink_q ^ tick_2hz;
      if (tick_1hz) begin
        phase_d = AR_2;
        cnt_d   = CNT_W'(ALL_RED);
      end
    end else if (tick_1hz) begin
      if (gap_out) begin
        phase_d = nxt_phase;
        cnt_d   = CNT_W'(YELLOW);
      end else if (cnt_q == CNT_W'(1)) begin
        phase_d = nxt_phase;
        cnt_d   = dur(nxt_phase);
      end else begin
        cnt_d   = cnt_q - CNT_W'(1);
      end
    end
  end

  // Lamps decode from the next state so they change on the same edge as phase
  always_comb begin
    ns_lamp_d = LAMP_RED;
    ew_lamp_d = LAMP_RED;
    case (phase_d)
      NS_G:     ns_lamp_d = LAMP_GRN;
      NS_Y:     ns_lamp_d = LAMP_YEL;
      EW_G:     ew_lamp_d = LAMP_GRN;
      EW_Y:     ew_lamp_d = LAMP_YEL;
      FAILSAFE: begin
        ns_lamp_d = blink_d ? LAMP_RED : LAMP_OFF;
        ew_lamp_d = blink_d ? LAMP_RED : LAMP_OFF;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q   <= AR_2;
      cnt_q     <= CNT_W'(ALL_RED);
      ns_lamp_q <= LAMP_RED;
      ew_lamp_q <= LAMP_RED;
    end else begin
      phase_q   <= phase_d;
      cnt_q     <= cnt_d;
      ns_lamp_q <= ns_lamp_d;
      ew_lamp_q <= ew_lamp_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blink_q <= 1'b1;
    end else begin
      blink_q <= blink_d;
    end
  end

  assign ns_lamp   = ns_lamp_q;
  assign ew_lamp   = ew_lamp_q;
  assign countdown = cnt_q;
  assign phase     = phase_q;

`ifndef SYNTHESIS
  a_one_approach_moving: assert property (@(posedge clk) disable iff (!rst_n)
    !((|ns_lamp_q[1:0]) && (|ew_lamp_q[1:0])));
`endif

endmodule

`default_nettype wire

// File: tb/tb_traffic_phase_fsm.sv
// ============================================================================
// Module      : tb_traffic_phase_fsm
// Description : Self-checking bench for traffic_phase_fsm with a sequence-table
//               reference model and randomized tick/fault/sensor stimulus.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_traffic_phase_fsm;
  import traffic_pkg::*;

  localparam int GNS  = 5;
  localparam int GEW  = 4;
  localparam int YEL  = 2;
  localparam int AR   = 1;
  localparam int MING = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tick_1hz = 1'b0;
  logic       tick_2hz = 1'b0;
  logic       fault = 1'b0;
  logic       car_ns = 1'b0;
  logic       car_ew = 1'b0;
  logic [2:0] ns_lamp, ew_lamp, phase;
  logic [7:0] countdown;

  always #5 clk = ~clk;

  traffic_phase_fsm #(
    .CNT_W(8), .GREEN_NS(GNS), .GREEN_EW(GEW),
    .YELLOW(YEL), .ALL_RED(AR), .MIN_GREEN(MING)
  ) dut (
    .clk(clk), .rst_n(rst_n), .tick_1hz(tick_1hz), .tick_2hz(tick_2hz),
    .fault(fault), .car_ns(car_ns), .car_ew(car_ew),
    .ns_lamp(ns_lamp), .ew_lamp(ew_lamp), .countdown(countdown), .phase(phase)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference: position in the six-step ring plus seconds left, or failsafe
  phase_e ring [6] = '{NS_G, NS_Y, AR_1, EW_G, EW_Y, AR_2};
  int     dur  [6] = '{GNS, YEL, AR, GEW, YEL, AR};
  int     m_pos, m_cd;
  bit     m_fs, m_blink;

  function automatic logic [2:0] m_phase();
    if (m_fs) return FAILSAFE;
    return ring[m_pos];
  endfunction

  function automatic logic [2:0] m_lamp(input int grn_pos);
    if (m_fs) return {m_blink, 2'b00};
    if (m_pos == grn_pos) return 3'b001;
    if (m_pos == grn_pos + 1) return 3'b010;
    return 3'b100;
  endfunction

  task automatic model_reset();
    m_pos = 5; m_cd = AR; m_fs = 1'b0; m_blink = 1'b1;
  endtask

  task automatic model_step(input bit t1, input bit t2, input bit f, input bit cn, input bit ce);
    bit gap;
    gap = 1'b0;
    if (f) begin
      m_blink = m_fs ? (m_blink ^ t2) : 1'b1;
      m_fs = 1'b1;
      m_cd = 0;
    end else if (m_fs) begin
      m_blink = m_blink ^ t2;
      if (t1) begin m_fs = 1'b0; m_pos = 5; m_cd = AR; end
    end else if (t1) begin
`ifdef GAP_OUT_EN
      gap = (m_pos == 0 && (GNS - m_cd) >= MING && !cn && ce) ||
            (m_pos == 3 && (GEW - m_cd) >= MING && !ce && cn);
`endif
      if (gap) begin
        m_pos = m_pos + 1; m_cd = YEL;
      end else if (m_cd == 1) begin
        m_pos = (m_pos + 1) % 6; m_cd = dur[m_pos];
      end else begin
        m_cd = m_cd - 1;
      end
    end
  endtask

  task automatic step(input bit t1, input bit t2, input bit f, input bit cn, input bit ce);
    tick_1hz = t1; tick_2hz = t2; fault = f; car_ns = cn; car_ew = ce;
    model_step(t1, t2, f, cn, ce);
    @(posedge clk);
    @(negedge clk);
    tick_1hz = 1'b0; tick_2hz = 1'b0;
  endtask

  task automatic advance_to(input phase_e target);
    int k;
    k = 0;
    while (phase !== target && k < 40) begin
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      k++;
    end
    n_vec++;
    if (phase !== target || countdown !== 8'(m_cd)) begin
      n_err++;
      $display("FAIL advance_to: phase=%0d cd=%0d after %0d ticks, expected phase=%0d cd=%0d",
               phase, countdown, k, target, m_cd);
    end
  endtask

  task automatic test_reset();
    #12;
    n_vec++;
    if (phase !== AR_2 || countdown !== 8'd1 || ns_lamp !== 3'b100 || ew_lamp !== 3'b100) begin
      n_err++;
      $display("FAIL reset: phase=%0d cd=%0d ns=%b ew=%b, expected 5/1/100/100",
               phase, countdown, ns_lamp, ew_lamp);
    end
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_first_green();
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    n_vec++;
    if (phase !== NS_G || countdown !== 8'd5 || ns_lamp !== 3'b001 || ew_lamp !== 3'b100) begin
      n_err++;
      $display("FAIL first_green: phase=%0d cd=%0d ns=%b ew=%b, expected 0/5/001/100",
               phase, countdown, ns_lamp, ew_lamp);
    end
    repeat (5) begin
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    n_vec++;
    if (phase !== NS_Y || countdown !== 8'd2 || ns_lamp !== 3'b010 || ew_lamp !== 3'b100) begin
      n_err++;
      $display("FAIL ns_yellow: phase=%0d cd=%0d ns=%b ew=%b, expected 1/2/010/100",
               phase, countdown, ns_lamp, ew_lamp);
    end
  endtask

  task automatic test_full_cycle();
    for (int i = 0; i < 15; i++) begin
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      n_vec++;
      if (phase !== m_phase() || countdown !== 8'(m_cd) ||
          ns_lamp !== m_lamp(0) || ew_lamp !== m_lamp(3)) begin
        n_err++;
        $display("FAIL cycle[%0d]: phase=%0d cd=%0d ns=%b ew=%b, expected %0d/%0d/%b/%b",
                 i, phase, countdown, ns_lamp, ew_lamp, m_phase(), m_cd, m_lamp(0), m_lamp(3));
      end
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    n_vec++;
    if (phase !== NS_Y || countdown !== 8'd2) begin
      n_err++;
      $display("FAIL cycle_wrap: phase=%0d cd=%0d, expected 1/2", phase, countdown);
    end
  endtask

  task automatic test_hold();
    int bad;
    bad = 0;
    advance_to(EW_G);
    repeat (1000) begin
      step(1'b0, 1'($urandom_range(0, 1)), 1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      if (phase !== EW_G || countdown !== 8'(m_cd) || ns_lamp !== 3'b100 || ew_lamp !== 3'b001)
        bad++;
    end
    n_vec++;
    if (bad != 0) begin
      n_err++;
      $display("FAIL hold: %0d of 1000 idle cycles changed, final phase=%0d cd=%0d ns=%b ew=%b, expected 3/%0d/100/001",
               bad, phase, countdown, ns_lamp, ew_lamp, m_cd);
    end
  endtask

  task automatic test_fault();
    bit exp_red;
    advance_to(NS_G);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    n_vec++;
    if (phase !== FAILSAFE || countdown !== 8'd0 || ns_lamp !== 3'b100 || ew_lamp !== 3'b100) begin
      n_err++;
      $display("FAIL fault_entry: phase=%0d cd=%0d ns=%b ew=%b, expected 6/0/100/100",
               phase, countdown, ns_lamp, ew_lamp);
    end
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
      exp_red = (i % 2 == 1);
      n_vec++;
      if (ns_lamp !== {exp_red, 2'b00} || ew_lamp !== {exp_red, 2'b00} || countdown !== 8'd0) begin
        n_err++;
        $display("FAIL blink[%0d]: ns=%b ew=%b cd=%0d, expected red=%0d cd=0",
                 i, ns_lamp, ew_lamp, countdown, exp_red);
      end
      step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    end
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    n_vec++;
    if (phase !== AR_2 || countdown !== 8'd1 || ns_lamp !== 3'b100 || ew_lamp !== 3'b100) begin
      n_err++;
      $display("FAIL fault_exit: phase=%0d cd=%0d ns=%b ew=%b, expected 5/1/100/100",
               phase, countdown, ns_lamp, ew_lamp);
    end
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    n_vec++;
    if (phase !== NS_G || countdown !== 8'd5) begin
      n_err++;
      $display("FAIL after_fault: phase=%0d cd=%0d, expected 0/5", phase, countdown);
    end
  endtask

  task automatic test_gap_out();
    logic [2:0] exp_ph;
    logic [7:0] exp_cd;
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    n_vec++;
    if (phase !== NS_G || countdown !== 8'd4) begin
      n_err++;
      $display("FAIL gap_early: phase=%0d cd=%0d, expected 0/4", phase, countdown);
    end
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
`ifdef GAP_OUT_EN
    exp_ph = NS_Y; exp_cd = 8'd2;
`else
    exp_ph = NS_G; exp_cd = 8'd2;
`endif
    n_vec++;
    if (phase !== exp_ph || countdown !== exp_cd || countdown !== 8'(m_cd)) begin
      n_err++;
      $display("FAIL gap_out: phase=%0d cd=%0d, expected %0d/%0d", phase, countdown, exp_ph, exp_cd);
    end
  endtask

  task automatic test_random();
    bit f;
    f = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 59) == 0) f = ~f;
      step(1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) == 0), f,
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      n_vec++;
      if (phase !== m_phase() || countdown !== 8'(m_cd) ||
          ns_lamp !== m_lamp(0) || ew_lamp !== m_lamp(3)) begin
        n_err++;
        $display("FAIL random[%0d]: phase=%0d cd=%0d ns=%b ew=%b, expected %0d/%0d/%b/%b",
                 i, phase, countdown, ns_lamp, ew_lamp, m_phase(), m_cd, m_lamp(0), m_lamp(3));
      end
    end
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_async_reset();
    advance_to(EW_Y);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_vec++;
    if (phase !== AR_2 || countdown !== 8'd1 || ns_lamp !== 3'b100 || ew_lamp !== 3'b100) begin
      n_err++;
      $display("FAIL async_reset: phase=%0d cd=%0d ns=%b ew=%b, expected 5/1/100/100",
               phase, countdown, ns_lamp, ew_lamp);
    end
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    n_vec++;
    if (phase !== m_phase() || countdown !== 8'(m_cd) || ns_lamp !== m_lamp(0)) begin
      n_err++;
      $display("FAIL post_reset: phase=%0d cd=%0d ns=%b, expected %0d/%0d/%b",
               phase, countdown, ns_lamp, m_phase(), m_cd, m_lamp(0));
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_first_green();
    test_full_cycle();
    test_hold();
    test_fault();
    test_gap_out();
    test_random();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, vectors=%0d", n_vec);
    $fatal(1);
  end

endmodule

`default_nettype wire
